// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the Sudoku board checker.
// Cell/grid typedefs, pass and FSM state enums, divide/modulo-by-3 helpers.
package sudoku_pkg;

   localparam int GRID_N    = 9;
   localparam int BOX_N     = 3;
   localparam int EMPTY     = 0;
   localparam int CELL_BITS = 4;

   typedef logic [CELL_BITS-1:0] cell_t;
   typedef cell_t [8:0][8:0]     grid_t;

   typedef enum logic [1:0] {
      ROW = 2'd0,
      COL = 2'd1,
      BOX = 2'd2
   } pass_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } chk_state_t;

   function automatic logic [3:0] div3(input logic [3:0] x);
      if (x >= 4'd6)      return 4'd2;
      else if (x >= 4'd3) return 4'd1;
      else                return 4'd0;
   endfunction

   function automatic logic [3:0] mod3(input logic [3:0] x);
      return x - 4'd3 * div3(x);
   endfunction

endpackage

// File: rtl/board_checker_cell_index_gen.sv
// Visit-order generator: pass/g/k counters and the cell (i,j) they address.
// Ports: clock, reset_n, clear, advance -> pass, i, j, first_in_group, last_visit.
module cell_index_gen
   import sudoku_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       advance,
   output pass_t      pass,
   output logic [3:0] i,
   output logic [3:0] j,
   output logic       first_in_group,
   output logic       last_visit
);

   logic [3:0] g;
   logic [3:0] k;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pass <= ROW;
         g    <= '0;
         k    <= '0;
      end else if (clear) begin
         pass <= ROW;
         g    <= '0;
         k    <= '0;
      end else if (advance) begin
         if (k == 4'd8) begin
            k <= '0;
            if (g == 4'd8) begin
               g <= '0;
               case (pass)
                  ROW:     pass <= COL;
                  COL:     pass <= BOX;
                  default: pass <= ROW;
               endcase
            end else begin
               g <= g + 4'd1;
            end
         end else begin
            k <= k + 4'd1;
         end
      end
   end

   always_comb begin
      i = g;
      j = k;
      case (pass)
         ROW: begin
            i = g;
            j = k;
         end
         COL: begin
            i = k;
            j = g;
         end
         BOX: begin
            i = 4'd3 * div3(g) + div3(k);
            j = 4'd3 * mod3(g) + mod3(k);
         end
         default: begin
            i = g;
            j = k;
         end
      endcase
   end

   assign first_in_group = (k == 4'd0);
   assign last_visit     = (pass == BOX) && (g == 4'd8) && (k == 4'd8);

endmodule

// File: rtl/board_checker.sv
// Sudoku board checker: snapshots the grid, scans rows/cols/boxes one cell per clock.
// Ports: clock, reset_n, start, display_grid -> busy, done, solved, conflict,
// conflict_i/j, empty_count; conflict_count when BOARD_CHECKER_FULL_SCAN_EN is defined
// (that macro also disables abort-on-first-conflict).
module board_checker
   import sudoku_pkg::*;
#(
   parameter int CELL_W = 4
)(
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [8:0][8:0][CELL_W-1:0]  display_grid,
   output logic                         busy,
   output logic                         done,
   output logic                         solved,
   output logic                         conflict,
   output logic [3:0]                   conflict_i,
   output logic [3:0]                   conflict_j,
   output logic [6:0]                   empty_count
`ifdef BOARD_CHECKER_FULL_SCAN_EN
   ,output logic [7:0]                  conflict_count
`endif
);

`ifdef BOARD_CHECKER_FULL_SCAN_EN
   localparam bit ABORT = 1'b0;
`else
   localparam bit ABORT = 1'b1;
`endif

   chk_state_t                  state;
   logic [8:0][8:0][CELL_W-1:0] snap;
   logic [8:0]                  seen;

   pass_t      pass;
   logic [3:0] ci;
   logic [3:0] cj;
   logic       first_in_group;
   logic       last_visit;

   logic              accept;
   logic              scanning;
   logic [CELL_W-1:0] v;
   logic              v_empty;
   logic              v_illegal;
   logic [8:0]        v_bit;
   logic [8:0]        seen_eff;
   logic              hit;
   logic              stop;
   logic [6:0]        empty_nxt;

   assign accept   = (state == IDLE) && start;
   assign scanning = (state == SCAN);

   cell_index_gen u_idx (
      .clock          (clock),
      .reset_n        (reset_n),
      .clear          (accept),
      .advance        (scanning),
      .pass           (pass),
      .i              (ci),
      .j              (cj),
      .first_in_group (first_in_group),
      .last_visit     (last_visit)
   );

   always_comb begin
      v         = snap[ci][cj];
      v_empty   = (v == '0);
      v_illegal = (int'(v) > 9);
      v_bit     = '0;
      if (!v_empty && !v_illegal)
         v_bit = 9'd1 << (v - 1'b1);
      // mask restarts at the first cell of each row/col/box
      seen_eff  = first_in_group ? '0 : seen;
      hit       = v_illegal || ((seen_eff & v_bit) != '0);
      empty_nxt = empty_count;
      if (pass == ROW && v_empty)
         empty_nxt = empty_count + 7'd1;
      stop      = last_visit || (ABORT && hit);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         snap        <= '0;
         seen        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         solved      <= 1'b0;
         conflict    <= 1'b0;
         conflict_i  <= '0;
         conflict_j  <= '0;
         empty_count <= '0;
`ifdef BOARD_CHECKER_FULL_SCAN_EN
         conflict_count <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  snap        <= display_grid;
                  seen        <= '0;
                  busy        <= 1'b1;
                  solved      <= 1'b0;
                  conflict    <= 1'b0;
                  conflict_i  <= '0;
                  conflict_j  <= '0;
                  empty_count <= '0;
`ifdef BOARD_CHECKER_FULL_SCAN_EN
                  conflict_count <= '0;
`endif
                  state       <= SCAN;
               end
            end
            SCAN: begin
               seen        <= seen_eff | v_bit;
               empty_count <= empty_nxt;
               // only the first offending cell is reported
               if (hit && !conflict) begin
                  conflict   <= 1'b1;
                  conflict_i <= ci;
                  conflict_j <= cj;
               end
`ifdef BOARD_CHECKER_FULL_SCAN_EN
               if (hit)
                  conflict_count <= conflict_count + 8'd1;
`endif
               // done rises with the move to DONE so it lasts exactly that state
               if (stop) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  solved <= !(conflict || hit) && (empty_nxt == '0);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
